// File: rtl/inst_mem_loader_if.sv
// Bundle of fetch, load and status signals between the openmips core/loader
// side and the instruction memory. Optional chksum_o exists only when
// INST_MEM_CHKSUM_EN is defined.
`timescale 1ns/1ps
interface inst_mem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rom_ce_i;
    logic [31:0]       rom_addr_i;
    logic [31:0]       rom_data_o;
    logic              load_start_i;
    logic              ld_valid_i;
    logic              ld_ready_o;
    logic [7:0]        ld_byte_i;
    logic              ld_last_i;
    logic              cpu_rst_o;
    logic [ADDR_W:0]   words_o;
    logic              ovf_o;
`ifdef INST_MEM_CHKSUM_EN
    logic [31:0]       chksum_o;

    modport master (
        output rom_ce_i, rom_addr_i, load_start_i, ld_valid_i, ld_byte_i, ld_last_i,
        input  rom_data_o, ld_ready_o, cpu_rst_o, words_o, ovf_o, chksum_o
    );
    modport slave (
        input  rom_ce_i, rom_addr_i, load_start_i, ld_valid_i, ld_byte_i, ld_last_i,
        output rom_data_o, ld_ready_o, cpu_rst_o, words_o, ovf_o, chksum_o
    );
`else
    modport master (
        output rom_ce_i, rom_addr_i, load_start_i, ld_valid_i, ld_byte_i, ld_last_i,
        input  rom_data_o, ld_ready_o, cpu_rst_o, words_o, ovf_o
    );
    modport slave (
        input  rom_ce_i, rom_addr_i, load_start_i, ld_valid_i, ld_byte_i, ld_last_i,
        output rom_data_o, ld_ready_o, cpu_rst_o, words_o, ovf_o
    );
`endif
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction memory for the openmips ROM fetch port, filled from a
// big-endian byte stream. Holds the core in reset until a load completes.
// Optional feature macro: INST_MEM_CHKSUM_EN (adds chksum_o, the mod-2^32
// sum of all words written by the current load).
`timescale 1ns/1ps
module inst_mem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    inst_mem_loader_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WORDS_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t              state_reg;
    logic [1:0]          byte_cnt_reg;
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W:0]     words_reg;
    logic                ovf_reg;
    logic                cpu_rst_reg;
    logic [31:0]         buf_reg;
    logic [31:0]         mem [0:DEPTH-1];

    logic                ready;
    logic                accept;
    logic                word_done;
    logic [4:0]          shift;
    logic [31:0]         merged_word;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.rom_addr_i[31:ADDR_W+2], bus.rom_addr_i[1:0]};

    // A start pulse always wins over a byte presented in the same cycle.
    assign ready     = (state_reg == LOAD) && !bus.load_start_i;
    assign accept    = ready && bus.ld_valid_i;
    assign word_done = accept && ((byte_cnt_reg == 2'd3) || bus.ld_last_i);

    // Merge the incoming byte into its big-endian lane; unfilled lanes stay zero,
    // which gives the padded partial word for free.
    always_comb begin
        shift       = {~byte_cnt_reg, 3'b000};
        merged_word = buf_reg | ({24'h0, bus.ld_byte_i} << shift);
    end

`ifdef INST_MEM_CHKSUM_EN
    logic [31:0] chksum_reg;

    // Running sum of every word written by the current load.
    always_ff @(posedge clk) begin
        if (rst || bus.load_start_i) begin
            chksum_reg <= 32'h0;
        end else if (word_done) begin
            chksum_reg <= chksum_reg + merged_word;
        end
    end

    assign bus.chksum_o = chksum_reg;
`endif

    // Control FSM: load sequencing, counters, overflow flag and core reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= 2'd0;
            wr_ptr_reg   <= '0;
            words_reg    <= '0;
            ovf_reg      <= 1'b0;
            cpu_rst_reg  <= 1'b1;
            buf_reg      <= 32'h0;
        end else if (bus.load_start_i) begin
            state_reg    <= LOAD;
            byte_cnt_reg <= 2'd0;
            wr_ptr_reg   <= '0;
            words_reg    <= '0;
            ovf_reg      <= 1'b0;
            cpu_rst_reg  <= 1'b1;
            buf_reg      <= 32'h0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (word_done) begin
                        wr_ptr_reg   <= wr_ptr_reg + PTR_ONE;
                        byte_cnt_reg <= 2'd0;
                        buf_reg      <= 32'h0;
                        // Top bit set means the array is already full: this
                        // write overwrites an earlier word.
                        if (words_reg[ADDR_W]) begin
                            ovf_reg <= 1'b1;
                        end else begin
                            words_reg <= words_reg + WORDS_ONE;
                        end
                        if (bus.ld_last_i) begin
                            state_reg   <= RUN;
                            cpu_rst_reg <= 1'b0;
                        end
                    end else if (accept) begin
                        buf_reg      <= merged_word;
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Word array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && word_done) begin
            mem[wr_ptr_reg] <= merged_word;
        end
    end

    // Same-cycle fetch, gated so the core only ever sees a completed image.
    assign bus.rom_data_o = (bus.rom_ce_i && (state_reg == RUN))
                          ? mem[bus.rom_addr_i[ADDR_W+1:2]] : 32'h0;

    assign bus.ld_ready_o = ready;
    assign bus.cpu_rst_o  = cpu_rst_reg;
    assign bus.words_o    = words_reg;
    assign bus.ovf_o      = ovf_reg;
endmodule
